// File: rtl/jtkunio_objscan.sv
// Per-line sprite scanner: after each hs rising edge it walks the object table and
// hands every sprite that intersects line vrender to the drawer over valid/ready.
//
// state | meaning
// IDLE  | after reset, waiting for the first hs edge
// RD0   | word 2n addressed
// RD1   | word 2n+1 addressed, word 2n arriving
// CHK   | word 2n+1 arriving, entry evaluated
// ISSUE | draw request presented, waiting for dr_ready
// DONE  | table finished or request budget used up
module jtkunio_objscan #(
    parameter int OBJS   = 128,
    parameter int MAXOBJ = 32
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        hs,
    input  logic [8:0]  vrender,
    input  logic        flip,
    output logic [9:0]  scan_addr,
    input  logic [15:0] scan_dout,
    output logic        dr_valid,
    input  logic        dr_ready,
    output logic [9:0]  dr_code,
    output logic [7:0]  dr_xpos,
    output logic [3:0]  dr_ysub,
    output logic        dr_hflip,
    output logic [2:0]  dr_pal,
    output logic        scan_done
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, CHK, ISSUE, DONE} state_t;

    state_t      state, state_nx;
    logic        hs_d, hs_rise;
    logic [8:0]  n, n_inc;
    logic [9:0]  hits, hits_inc;
    logic [15:0] word0;
    logic        last, hit, tall;
    logic [7:0]  obj_y, obj_x, attr, code;
    logic [7:0]  vf, dy, h, row;
    logic        unused_bits;

    assign unused_bits = ^{vrender[8], row[7:5]};

    assign hs_rise  = hs & ~hs_d;
    assign n_inc    = n + 9'd1;
    assign hits_inc = hits + 10'd1;
    assign last     = (n == 9'(OBJS - 1));

    // word0 was latched in RD1; word1 is on scan_dout during CHK
    assign obj_y = word0[7:0];
    assign attr  = word0[15:8];
    assign code  = scan_dout[7:0];
    assign obj_x = scan_dout[15:8];
    assign tall  = attr[1];
    assign vf    = vrender[7:0] ^ {8{flip}};
    assign dy    = vf - obj_y;
    assign h     = tall ? 8'd32 : 8'd16;
    assign hit   = attr[0] & (dy < h);
    assign row   = flip ? (h - 8'd1 - dy) : dy;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (hs_rise) begin
            state_nx = RD0;
        end else begin
            case (state)
                RD0:   state_nx = RD1;
                RD1:   state_nx = CHK;
                CHK: begin
                    if (hit)       state_nx = ISSUE;
                    else if (last) state_nx = DONE;
                    else           state_nx = RD0;
                end
                ISSUE: begin
                    if (dr_ready) begin
                        if (hits_inc == 10'(MAXOBJ) || last) state_nx = DONE;
                        else                                 state_nx = RD0;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d      <= 1'b0;
            n         <= '0;
            hits      <= '0;
            word0     <= '0;
            scan_addr <= '0;
            dr_valid  <= 1'b0;
            dr_code   <= '0;
            dr_xpos   <= '0;
            dr_ysub   <= '0;
            dr_hflip  <= 1'b0;
            dr_pal    <= '0;
            scan_done <= 1'b1;
        end else begin
            hs_d <= hs;
            if (hs_rise) begin
                // restart drops any pending request without a transfer
                n         <= '0;
                hits      <= '0;
                dr_valid  <= 1'b0;
                scan_done <= 1'b0;
                scan_addr <= '0;
            end else begin
                case (state)
                    RD0: scan_addr <= {n, 1'b1};
                    RD1: word0 <= scan_dout;
                    CHK: begin
                        if (hit) begin
                            dr_valid <= 1'b1;
                            dr_code  <= {attr[3:2], code} + {9'd0, row[4]};
                            dr_xpos  <= flip ? (8'd240 - obj_x) : obj_x;
                            dr_ysub  <= row[3:0];
                            dr_hflip <= attr[7] ^ flip;
                            dr_pal   <= attr[6:4];
                        end else begin
                            n <= n_inc;
                        end
                    end
                    ISSUE: begin
                        if (dr_ready) begin
                            dr_valid <= 1'b0;
                            hits     <= hits_inc;
                            n        <= n_inc;
                        end
                    end
                    default: ;
                endcase
                if (state_nx == RD0 && (state == CHK || state == ISSUE))
                    scan_addr <= {n_inc, 1'b0};
                if (state_nx == DONE)
                    scan_done <= 1'b1;
            end
        end
    end

endmodule
